// File: rtl/sample_normalizer.sv
// Sample normalizer: shifts a sample left until its most significant
// bit (logical mode) or its sign boundary (arithmetic mode) reaches the
// top of the word. Reports the normalized value, the shift count and
// whether the sample had no significant bits at all.
module sample_normalizer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm,
  output logic [WIDTH-1:0] amt,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] count_reg;
  logic             mode_reg;
  logic             is_norm;
  logic             is_zero;

  // Normalization test on the working register. In arithmetic mode the
  // value is normalized once the sign bit differs from the bit below it.
  always_comb begin
    is_zero = (work_reg == '0);
    if (mode_reg) begin
      is_norm = work_reg[WIDTH-1] ^ work_reg[WIDTH-2];
    end else begin
      is_norm = work_reg[WIDTH-1];
    end
  end

  // Control FSM with registered outputs. Results are only written when
  // leaving SHIFT, so they stay stable during the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      norm      <= '0;
      amt       <= '0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg  <= din;
            mode_reg  <= mode;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (is_zero) begin
            zero      <= 1'b1;
            norm      <= '0;
            amt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (is_norm) begin
            zero      <= 1'b0;
            norm      <= work_reg;
            amt       <= count_reg;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            // A nonzero value always normalizes by count WIDTH-1, since
            // the last one bit reaching the top is itself a boundary.
            work_reg  <= {work_reg[WIDTH-2:0], 1'b0};
            count_reg <= count_reg + ONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_normalizer.sv
// Randomized and directed bench for sample_normalizer, checked against a
// leading-bit-count reference model.
module tb_sample_normalizer;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] din;
  logic         mode;
  logic         busy;
  logic         done;
  logic [W-1:0] norm;
  logic [W-1:0] amt;
  logic         zero;

  int total;
  int bad;

  sample_normalizer #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .din  (din),
    .mode (mode),
    .busy (busy),
    .done (done),
    .norm (norm),
    .amt  (amt),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: amt is the number of redundant leading bits (leading zeros
  // in logical mode, leading sign copies minus one in arithmetic mode).
  task automatic model(input logic [W-1:0] d, input logic m,
                       output logic [W-1:0] e_norm, output logic [W-1:0] e_amt,
                       output logic e_zero);
    int  n;
    bit  run;
    n   = 0;
    run = 1;
    if (d == '0) begin
      e_norm = '0;
      e_amt  = '0;
      e_zero = 1'b1;
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (run && (d[i] == (m ? d[W-1] : 1'b0))) n++;
        else run = 0;
      end
      if (m) n = n - 1;
      e_amt  = W'(n);
      e_norm = d << n;
      e_zero = 1'b0;
    end
  endtask

  // Team shifter: non-negative b shifts left; arithmetic left equals logical.
  function automatic logic [W-1:0] shifter(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ctrl);
    logic signed [W-1:0] sa;
    sa = a;
    if (ctrl) return W'(sa <<< b);
    return a << b;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [W-1:0] d, input logic m, input bit disturb);
    logic [W-1:0] en, ea;
    logic         ez;
    logic [W-1:0] prev_norm;
    int           cyc;
    int           extra;
    bit           got, busy_ok, stable_ok;
    model(d, m, en, ea, ez);
    prev_norm = norm;
    din   = d;
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
    din   = W'($urandom);
    mode  = 1'($urandom);
    cyc = 0; got = 0; busy_ok = 1; stable_ok = 1;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      if (done) got = 1;
      else begin
        if (!busy) busy_ok = 0;
        if (norm !== prev_norm) stable_ok = 0;
      end
      if (disturb && cyc == 3 && !got) begin
        start = 1'b1;
        din   = ~d;
        mode  = ~m;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(ea) + 32'd1);
    check("busy_in_shift", 32'(busy_ok), 32'd1);
    check("hold_in_shift", 32'(stable_ok), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("norm", 32'(norm), 32'(en));
    check("amt", 32'(amt), 32'(ea));
    check("zero", 32'(zero), 32'(ez));
    if (!ez) check("shifter", 32'(shifter(d, amt, m)), 32'(norm));
    step();
    check("done_pulse", 32'(done), 32'd0);
    check("norm_hold", 32'(norm), 32'(en));
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra++;
    end
    check("no_extra_done", 32'(extra), 32'd0);
    $display("run din=0x%04h mode=%0d disturb=%0d -> norm=0x%04h amt=%0d zero=%0d cycles=%0d",
             d, m, disturb, norm, amt, zero, cyc);
  endtask

  initial begin
    logic [W-1:0] d;
    int extra;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    mode  = 1'b0;
    step();
    step();
    check("reset_state", 32'({busy, done, zero, norm, amt}), 32'd0);
    reset = 1'b0;

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    din   = 16'h0001;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("reset_over_start", 32'(busy), 32'd0);
    step();
    check("idle_after_reset", 32'(busy), 32'd0);

    run(16'h0001, 1'b0, 0);
    run(16'h0003, 1'b1, 0);
    run(16'h4000, 1'b1, 0);
    run(16'h8000, 1'b0, 0);
    run(16'hFFFF, 1'b1, 0);
    run(16'h0000, 1'b0, 0);
    run(16'h0000, 1'b1, 0);
    run(16'h0010, 1'b0, 1);
    run(16'hFFF0, 1'b1, 1);

    // Reset in the middle of SHIFT abandons the request.
    din   = 16'h0002;
    mode  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_outputs", 32'({busy, done, zero, norm, amt}), 32'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra++;
    end
    check("mid_reset_no_done", 32'(extra), 32'd0);
    $display("mid-shift reset: done pulses after reset=%0d", extra);
    run(16'h0002, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      d = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 7) == 0) d = '0;
      if ($urandom_range(0, 7) == 0) d = ~d;
      run(d, 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
